uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//  Serial-to-parallel UART receiver; the downstream stage that consumes the Tx line of our transmitter.
//  Idle high, 1 start bit (0), N data bits LSB first, optional parity, 1 stop bit (1).
//  Samples each bit at mid-bit using a programmable clocks-per-bit divisor, then presents the word with a 1-cycle valid pulse.
// PARAMETERS
//  N            8   data bits per frame (5..9)
//  SYNC_STAGES  2   flip-flops in the rx input synchronizer (>=2)
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  arst        in   1   asynchronous reset, active-high
//  rst         in   1   synchronous soft reset, active-high; same effect as arst
//  rx_en       in   1   receiver enable
//  rx          in   1   serial line, asynchronous to clk
//  Load_Value  in   10  clocks per bit; latched at start-bit detect
//  data        out  N   last received word; held until next frame completes
//  valid       out  1   1-cycle pulse: data updated, frame good
//  busy        out  1   high in any state other than IDLE
//  frame_err   out  1   1-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  Reset (arst or rst): state=IDLE, data=0, valid=0, busy=0, frame_err=0; synchronizer preset to 1 (line idle).
//  rxs = rx after SYNC_STAGES flops; all decisions use rxs.
//  Divisor: div = latched Load_Value; values 0..3 are clamped to 4. half = div>>1.
//  Bit counter: 10-bit baud counter plus 4-bit bit index; counter reloads on every sample point.
//  FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
//   IDLE : rx_en=1 and rxs falling edge (prev 1, now 0) -> START; latch div; clear counter. Cycle of detection = t0.
//   START: sample at t0+half. rxs=0 -> DATA; rxs=1 -> glitch, return to IDLE, no outputs.
//   DATA : bit i sampled at t0+half+(i+1)*div, shifted in LSB first; after bit N-1 -> PARITY or STOP.
//   STOP : sample at t0+half+(N+1)*div (+div if parity). Return to IDLE next cycle.
//  Outputs on stop sample (registered, visible the cycle after the sample):
//   rxs=1 and no error -> data<=word, valid=1.
//   rxs=0 -> frame_err=1, data unchanged, valid=0.
//  valid and frame_err never both high; neither asserts outside that single cycle.
//  Line held low after a bad stop (break): IDLE needs a new 1->0 edge, so no retrigger until the line returns high.
//  rx_en deasserted mid-frame: abort to IDLE next cycle, no valid/err, data unchanged.
//  Load_Value changed mid-frame: ignored until next start detect.
//  rst mid-frame: same as arst, no pulse emitted for the partial frame.
//  Back-to-back frames: a start edge arriving in the IDLE cycle right after STOP is accepted; no dead time beyond one cycle.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   PARITY state after DATA; parity bit sampled at t0+half+(N+1)*div; even parity (XOR of data+parity must be 0).
//   Extra port parity_err out 1: 1-cycle pulse at stop-sample time when parity fails.
//   On parity fail with good stop: data updated, valid=0, parity_err=1.
//  Not defined: no PARITY state, no parity_err port, frame is 1+N+1 bits.
// TESTING
//  1. Load_Value=16, send 0xA5 (8N1) -> valid pulse exactly 1 cycle at t0+8+9*16+1, data=0xA5, frame_err=0.
//  2. Load_Value=16, stop bit driven 0 for 0x3C -> frame_err pulse, valid=0, data keeps previous value; no retrigger while line stays low.
//  3. Load_Value=16, 4-cycle low glitch on idle line -> START rejects at mid-bit, busy drops, no valid/err.
//  4. Send 0x00 then 0xFF back-to-back at Load_Value=10, then Load_Value=2 (clamped to 4) frame 0x55 -> three valid pulses, data 0x00,0xFF,0x55.
//  5. rx_en=0 at bit 3 of frame, and separately arst pulse at bit 5 -> busy=0 next cycle, no valid, data unchanged; next clean frame 0x81 received.
//  6. UART_RX_PARITY_EN: 0x07 with parity 1 -> valid, data=0x07; same with parity 0 -> parity_err pulse, valid=0.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: serial-to-parallel UART receiver.
// Frame is idle-high, one start bit (0), N data bits LSB first, an optional
// even-parity bit, and one stop bit (1). Each bit is sampled once at mid-bit
// using a clocks-per-bit divisor latched at start-bit detection.
// The received word is presented with a single-cycle valid pulse.
// Optional feature: define UART_RX_PARITY_EN to add the even-parity bit,
// the PARITY state and the parity_err output port.

module uart_rx_core #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         rst,
    input  logic         rx_en,
    input  logic         rx,
    input  logic [9:0]   Load_Value,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         busy,
    output logic         frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Divisors below 4 would leave no room between the half-bit and
    // full-bit sample points, so they are raised to this floor.
    localparam logic [9:0] MIN_DIV   = 10'd4;
    localparam logic [3:0] LAST_BIT  = 4'(N - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev;

    logic [2:0]             state;
    logic [9:0]             div;
    logic [9:0]             half;
    logic [9:0]             baud_cnt;
    logic [3:0]             bit_idx;
    logic [N-1:0]           shreg;

    logic                   start_edge;
    logic                   sample_tick;
    logic                   data_sample;
    logic                   stop_sample;

`ifdef UART_RX_PARITY_EN
    logic                   par_bit;
    logic                   par_sample;
    logic                   parity_ok;
`endif

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign half       = {1'b0, div[9:1]};
    assign start_edge = rx_en & rxs_prev & ~rxs;

    // The start bit is sampled half a bit after detection; every later
    // sample point is one full divisor after the previous one.
    assign sample_tick = (state == ST_START) ? (baud_cnt == half - 10'd1)
                                             : (baud_cnt == div - 10'd1);

    assign data_sample = rx_en & sample_tick & (state == ST_DATA);
    assign stop_sample = rx_en & sample_tick & (state == ST_STOP);
    assign busy        = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign par_sample  = rx_en & sample_tick & (state == ST_PARITY);
    assign parity_ok   = ~(^{shreg, par_bit});
`endif

    // Bring the asynchronous line into the clock domain; preset high so a
    // reset looks like an idle line and cannot fake a start edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else if (rst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev <= rxs;
        end
    end

    // Frame sequencing: start detection, baud counting and bit indexing.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_IDLE;
            div      <= MIN_DIV;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (rst) begin
            state    <= ST_IDLE;
            div      <= MIN_DIV;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state    <= ST_START;
                        div      <= (Load_Value < MIN_DIV) ? MIN_DIV : Load_Value;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end
                end
                default: begin
                    if (!rx_en) begin
                        state <= ST_IDLE;
                    end else if (sample_tick) begin
                        baud_cnt <= '0;
                        case (state)
                            ST_START: begin
                                state <= rxs ? ST_IDLE : ST_DATA;
                            end
                            ST_DATA: begin
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                    state <= ST_PARITY;
`else
                                    state <= ST_STOP;
`endif
                                end
                            end
`ifdef UART_RX_PARITY_EN
                            ST_PARITY: begin
                                state <= ST_STOP;
                            end
`endif
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        baud_cnt <= baud_cnt + 10'd1;
                    end
                end
            endcase
        end
    end

    // Shift in data bits and publish the word and status pulses at the stop sample.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else if (rst) begin
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            if (par_sample) begin
                par_bit <= rxs;
            end
`endif
            if (data_sample) begin
                shreg <= {rxs, shreg[N-1:1]};
            end
            if (stop_sample) begin
                if (rxs) begin
                    data <= shreg;
`ifdef UART_RX_PARITY_EN
                    valid      <= parity_ok;
                    parity_err <= ~parity_ok;
`else
                    valid      <= 1'b1;
`endif
                end else begin
                    frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= ~parity_ok;
`endif
                end
            end
        end
    end

endmodule
